// File: rtl/prog_matched_filter.sv
// Runtime-programmable SSR FIR matched filter; latency 3+clog2(NTAPS), no data backpressure; coefficient
// stream stalls only for the one-cycle bank swap. PROG_MF_SATURATE_EN selects saturating output and adds sat_o.
module prog_matched_filter #(
   parameter int NBITS  = 12,
   parameter int NSAMPS = 8,
   parameter int NTAPS  = 42,
   parameter int CBITS  = 4,
   parameter int OBITS  = 18
) (
   input  logic                      aclk,
   input  logic                      arst,
   input  logic [NBITS*NSAMPS-1:0]   data_i,
   output logic [OBITS*NSAMPS-1:0]   data_o,
`ifdef PROG_MF_SATURATE_EN
   output logic                      sat_o,
`endif
   input  logic [CBITS-1:0]          coef_tdata,
   input  logic                      coef_tvalid,
   output logic                      coef_tready,
   input  logic                      coef_tlast,
   output logic                      coef_update,
   output logic                      coef_err
);

   localparam int LG = $clog2(NTAPS);
   localparam int FW = NBITS + CBITS + LG;
   localparam int TP = 1 << LG;
   localparam int ND = (NTAPS - 1 + NSAMPS - 1) / NSAMPS;
   localparam int DL = (ND > 0) ? ND : 1;
   localparam int WN = NSAMPS * (ND + 1);
   localparam int CW = $clog2(NTAPS + 1);
   localparam logic [OBITS-1:0] OMAX = {1'b0, {(OBITS-1){1'b1}}};
   localparam logic [OBITS-1:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            rdy_en;
   logic            acc;
   logic            wr_en;
   logic            err_set;

   logic signed [CBITS-1:0] shadow [0:NTAPS-1];
   logic signed [CBITS-1:0] active [0:NTAPS-1];

   logic signed [NBITS-1:0] in_reg [0:NSAMPS-1];
   logic signed [NBITS-1:0] dly    [0:DL-1][0:NSAMPS-1];
   logic signed [NBITS-1:0] win    [0:WN-1];
   logic signed [FW-1:0]    tree   [0:LG][0:NSAMPS-1][0:TP-1];
   logic [OBITS-1:0]        out_v  [0:NSAMPS-1];
`ifdef PROG_MF_SATURATE_EN
   logic [NSAMPS-1:0]       clip;
`endif

   function automatic logic signed [FW-1:0] sxd(input logic signed [NBITS-1:0] v);
      return FW'(v);
   endfunction

   function automatic logic signed [FW-1:0] sxc(input logic signed [CBITS-1:0] v);
      return FW'(v);
   endfunction

   // tready is held low until the first clock after reset and during the swap cycle
   assign coef_tready = rdy_en & (state != SWAP);
   assign coef_update = (state == SWAP);
   assign acc         = coef_tvalid & coef_tready;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         cnt    <= '0;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rdy_en <= 1'b1;
      end
   end

   // IDLE and LOAD differ only in name: cnt is 0 in IDLE, so the same rules place h[0]
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (acc) begin
               wr_en = 1'b1;
               if (coef_tlast) begin
                  cnt_nxt = '0;
                  if (int'(cnt) + 1 == NTAPS) begin
                     state_nxt = SWAP;
                  end else begin
                     err_set   = 1'b1;
                     state_nxt = IDLE;
                  end
               end else if (int'(cnt) + 1 == NTAPS) begin
                  cnt_nxt   = '0;
                  state_nxt = DRAIN;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         DRAIN: begin
            if (acc && coef_tlast) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         SWAP: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < NTAPS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         coef_err <= 1'b0;
      end else begin
         if (wr_en) shadow[cnt] <= coef_tdata;
         if (state == SWAP) begin
            for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
         end
         if (err_set)           coef_err <= 1'b1;
         else if (state == SWAP) coef_err <= 1'b0;
      end
   end

   // Oldest delay block at the low end of the window, current input block at the top
   always_comb begin
      for (int i = 0; i < WN; i++) win[i] = '0;
      for (int b = 0; b < ND; b++) begin
         for (int k = 0; k < NSAMPS; k++) win[(ND-1-b)*NSAMPS + k] = dly[b][k];
      end
      for (int k = 0; k < NSAMPS; k++) win[ND*NSAMPS + k] = in_reg[k];
   end

   // Products read the active bank in the cycle after the block is captured, so the block
   // sampled during the swap cycle is the first to meet the new set on every tap and lane.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < NSAMPS; k++) begin
            in_reg[k] <= '0;
            for (int b = 0; b < DL; b++) dly[b][k] <= '0;
            for (int l = 0; l <= LG; l++) begin
               for (int i = 0; i < TP; i++) tree[l][k][i] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < NSAMPS; k++) begin
            in_reg[k] <= data_i[NBITS*k +: NBITS];
            dly[0][k] <= in_reg[k];
            for (int b = 1; b < DL; b++) dly[b][k] <= dly[b-1][k];
            for (int t = 0; t < NTAPS; t++)
               tree[0][k][t] <= sxd(win[ND*NSAMPS + k - t]) * sxc(active[t]);
            for (int l = 1; l <= LG; l++) begin
               for (int i = 0; i < (TP >> l); i++)
                  tree[l][k][i] <= tree[l-1][k][2*i] + tree[l-1][k][2*i+1];
            end
         end
      end
   end

   generate
      if (OBITS >= FW) begin : g_ext
         always_comb begin
            for (int k = 0; k < NSAMPS; k++) out_v[k] = OBITS'(tree[LG][k][0]);
`ifdef PROG_MF_SATURATE_EN
            clip = '0;
`endif
         end
      end else begin : g_nar
         always_comb begin
`ifdef PROG_MF_SATURATE_EN
            clip = '0;
            for (int k = 0; k < NSAMPS; k++) begin
               out_v[k] = tree[LG][k][0][OBITS-1:0];
               if (tree[LG][k][0][FW-1:OBITS-1] != '0 && tree[LG][k][0][FW-1:OBITS-1] != '1) begin
                  clip[k]  = 1'b1;
                  out_v[k] = tree[LG][k][0][FW-1] ? OMIN : OMAX;
               end
            end
`else
            for (int k = 0; k < NSAMPS; k++) out_v[k] = tree[LG][k][0][OBITS-1:0];
`endif
         end
      end
   endgenerate

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         data_o <= '0;
`ifdef PROG_MF_SATURATE_EN
         sat_o  <= 1'b0;
`endif
      end else begin
         for (int k = 0; k < NSAMPS; k++) data_o[OBITS*k +: OBITS] <= out_v[k];
`ifdef PROG_MF_SATURATE_EN
         sat_o  <= |clip;
`endif
      end
   end

endmodule
